// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Pure definitions: no logic, no latency, no flow control.
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is visible combinationally.
// Push to pop: 1 cycle. No internal backpressure: the caller must never push when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output fetch_entry_t  dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Credit accounting upstream is what keeps this from ever firing.
  assert property (@(posedge clk) disable iff (!rst) !(push && full));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, prefetch queue, redirect flush. FETCH_PERF_EN adds stall/flush counters.
// Latency: request accept to instr_valid = memory latency + 1. Decode backpressure throttles requests via queue credits.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter int               MAX_OUT  = 2,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
`endif
);
  localparam int QW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  logic             run;
  logic [WIDTH-1:0] fetch_pc;
  logic [OW-1:0]    kill;
  logic [OW-1:0]    out_cnt;
  logic [QW-1:0]    q_count;
  logic             q_full, q_empty, af_full, af_empty;
  logic             accept, q_push, q_pop;
  fetch_entry_t     q_din, q_dout, af_din, af_dout;
  logic             unused_bits;

  // run holds requests off until the first edge after reset release.
  assign imem_req_valid = run && !redirect && !af_full &&
                          (32'(q_count) + 32'(out_cnt) < 32'(DEPTH));
  assign imem_addr      = {fetch_pc[WIDTH-1:2], 2'b00};
  assign accept         = imem_req_valid && imem_req_ready;
  assign q_push         = imem_rsp_valid && (kill == '0) && !redirect;
  assign q_pop          = instr_valid && instr_ready && !redirect;
  assign instr_valid    = !q_empty;
  assign instr          = WIDTH'(q_dout.instr);
  assign instr_pc       = WIDTH'(q_dout.pc);
  assign q_din          = '{instr: 32'(imem_rsp_data), pc: af_dout.pc};
  assign af_din         = '{instr: NOP, pc: 32'(imem_addr)};
  assign unused_bits    = ^{redirect_pc[1:0], af_dout.instr, af_empty, q_full};

  fetch_fifo #(.DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst(rst), .push(q_push), .din(q_din), .pop(q_pop), .flush(redirect),
    .full(q_full), .empty(q_empty), .count(q_count), .dout(q_dout)
  );

  // Every response, killed or not, retires its request address here.
  fetch_fifo #(.DEPTH(MAX_OUT)) u_inflight (
    .clk(clk), .rst(rst), .push(accept), .din(af_din), .pop(imem_rsp_valid), .flush(1'b0),
    .full(af_full), .empty(af_empty), .count(out_cnt), .dout(af_dout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      kill     <= '0;
    end else begin
      run <= 1'b1;
      if (redirect) begin
        fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00};
        kill     <= out_cnt - OW'(imem_rsp_valid) + OW'(accept);
      end else begin
        if (accept) fetch_pc <= fetch_pc + WIDTH'(INSTR_BYTES);
        if (imem_rsp_valid && (kill != '0)) kill <= kill - OW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  localparam bit PERF_EN = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (instr_ready && !instr_valid && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (redirect && (flush_count != '1)) flush_count <= flush_count + 32'd1;
    end
  end
`else
  localparam bit PERF_EN = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_fetch_unit;
  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  fetch_unit dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  int          t0 = 0;
  int          first_acc = -1;
  int          first_iv = -1;
  logic        obs_req, obs_iv;
  logic [31:0] obs_ipc;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] acc[$];
  logic [31:0] got[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc.size()) ? acc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic mem_clear();
    q_addr.delete();
    q_due.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  endtask

  // Called at a negedge with this cycle's stimulus already applied.
  task automatic cycle();
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(q_addr[0]);
      q_addr.delete(0);
      q_due.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    obs_req = imem_req_valid;
    obs_iv  = instr_valid;
    obs_ipc = instr_pc;
    if (imem_req_valid && imem_req_ready) begin
      q_addr.push_back(imem_addr);
      q_due.push_back(cyc + lat);
      acc.push_back(imem_addr);
      if (first_acc < 0) first_acc = cyc;
    end
    if (instr_valid && first_iv < 0) first_iv = cyc;
    if (instr_valid && instr_ready && !redirect) begin
      got.push_back(instr_pc);
      chk("instr_word", instr, word(instr_pc));
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect = 1'b0;
    mem_clear();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    acc.delete();
    got.delete();
    first_acc = -1;
    first_iv  = -1;
    t0 = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);

    // Streaming at latency 1
    lat = 1;
    do_reset();
    repeat (12) cycle();
    chk("t1_first_req_cycle", first_acc - t0, 1);
    chk("t1_accept_to_valid", first_iv - first_acc, 2);
    for (int i = 0; i < 6; i++) begin
      chk("t1_addr", acc_at(i), 32'(4 * i));
      chk("t1_pc", got_at(i), 32'(4 * i));
    end
    chk("t1_one_per_cycle", got.size(), 9);

    // Decode stall fills the queue, then drains
    instr_ready = 1'b0;
    do_reset();
    repeat (10) cycle();
    chk("t2_requests_stop", acc.size(), 4);
    chk("t2_req_valid_low", obs_req, 0);
    chk("t2_instr_valid", obs_iv, 1);
    chk("t2_head_pc", obs_ipc, 0);
    instr_ready = 1'b1;
    repeat (10) cycle();
    for (int i = 0; i < 6; i++) chk("t2_drain_pc", got_at(i), 32'(4 * i));
    chk("t2_resume_addr", acc_at(4), 32'd16);
    chk("t2_no_bubble", got.size(), 10);

    // Redirect with two requests in flight at latency 3
    lat = 3;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h20;
    cycle();
    redirect = 1'b0;
    repeat (2) cycle();
    chk("t3_outstanding", acc.size(), 2);
    chk("t3_addr0", acc_at(0), 32'h20);
    chk("t3_addr1", acc_at(1), 32'h24);
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    chk("t3_no_req_on_redirect", obs_req, 0);
    redirect = 1'b0;
    acc.delete(); got.delete();
    repeat (12) cycle();
    chk("t3_new_addr", acc_at(0), 32'h100);
    chk("t3_pc0", got_at(0), 32'h100);
    chk("t3_pc1", got_at(1), 32'h104);
    chk("t3_pc2", got_at(2), 32'h108);

    // Redirect on a response cycle with another request still in flight
    lat = 2;
    do_reset();
    begin
      int n = 0;
      while (!(q_due.size() >= 2 && q_due[0] <= cyc && got.size() >= 1) && n < 30) begin
        cycle();
        n++;
      end
      chk("t4_setup_reached", 32'(n < 30), 1);
    end
    redirect = 1'b1; redirect_pc = 32'h103;
    cycle();
    chk("t4_no_req_on_redirect", obs_req, 0);
    redirect = 1'b0;
    acc.delete(); got.delete();
    cycle();
    chk("t4_flushed", obs_iv, 0);
    repeat (14) cycle();
    chk("t4_aligned_addr", acc_at(0), 32'h100);
    chk("t4_pc0", got_at(0), 32'h100);
    chk("t4_pc1", got_at(1), 32'h104);
    chk("t4_pc2", got_at(2), 32'h108);

    // Back-to-back redirects, last one wraps the address space
    lat = 1;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    acc.delete(); got.delete();
    repeat (8) cycle();
    chk("t5_addr0", acc_at(0), 32'hFFFF_FFFC);
    chk("t5_addr1", acc_at(1), 32'h0);
    chk("t5_pc0", got_at(0), 32'hFFFF_FFFC);
    chk("t5_pc1", got_at(1), 32'h0);
    chk("t5_pc2", got_at(2), 32'h4);
`ifdef FETCH_PERF_EN
    chk("t5_flush_count", flush_count, 2);
`endif

    // Asynchronous reset between clock edges
    repeat (3) cycle();
    #3 rst = 1'b0;
    #1;
    chk("t6_req_valid", imem_req_valid, 0);
    chk("t6_instr_valid", instr_valid, 0);
    chk("t6_instr", instr, 0);
    chk("t6_instr_pc", instr_pc, 0);
    chk("t6_addr", imem_addr, 0);
`ifdef FETCH_PERF_EN
    chk("t6_stall_cycles", stall_cycles, 0);
    chk("t6_flush_count", flush_count, 0);
`endif
    mem_clear();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    acc.delete(); got.delete();
    repeat (8) cycle();
    chk("t6_restart_addr0", acc_at(0), 32'h0);
    chk("t6_restart_addr1", acc_at(1), 32'h4);
    chk("t6_restart_pc0", got_at(0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
